// File: rtl/rv_div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Special cases (divide by zero, signed overflow) bypass the iteration and finish in one cycle.
module rv_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [XLEN-1:0]    rem;
   logic [XLEN-1:0]    quo;
   logic [XLEN-1:0]    divisor;
   logic [CW-1:0]      cnt;
   logic               is_rem;
   logic               neg_q;
   logic               neg_r;

   logic               sgn;
   logic               a_neg;
   logic               b_neg;
   logic               ovf;
   logic [XLEN-1:0]    a_mag;
   logic [XLEN-1:0]    b_mag;
   logic [XLEN:0]      trial;

   function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

   always_comb begin
      sgn   = ~op[0];
      a_neg = sgn & a[XLEN-1];
      b_neg = sgn & b[XLEN-1];
      a_mag = a_neg ? neg2c(a) : a;
      b_mag = b_neg ? neg2c(b) : b;
      ovf   = sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      // Shifted partial remainder minus divisor; the extra MSB is the borrow
      trial = {rem, quo[XLEN-1]} - {1'b0, divisor};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         cnt     <= '0;
         is_rem  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  is_rem  <= op[1];
                  neg_q   <= a_neg ^ b_neg;
                  neg_r   <= a_neg;
                  divisor <= b_mag;
                  rem     <= '0;
                  quo     <= a_mag;
                  cnt     <= CW'(XLEN - 1);
                  if (b == '0) begin
                     result <= op[1] ? a : '1;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else if (ovf) begin
                     result <= op[1] ? '0 : a;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (!trial[XLEN]) begin
                  rem <= trial[XLEN-1:0];
                  quo <= {quo[XLEN-2:0], 1'b1};
               end else begin
                  rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                  quo <= {quo[XLEN-2:0], 1'b0};
               end
               cnt <= cnt - CW'(1);
               if (cnt == '0) state <= FIX;
            end
            FIX: begin
               // Remainder follows the dividend's sign, quotient the XOR of both signs
               if (is_rem) result <= neg_r ? neg2c(rem) : rem;
               else        result <= neg_q ? neg2c(quo) : quo;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_div_unit.sv
// Bench for rv_div_unit: cycle-level reference model with per-cycle compare,
// directed RV32M cases with literal expectations, and randomized operations.
module tb_rv_div_unit;

   localparam int XLEN = 32;
   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   logic            clk = 1'b0;
   logic            rst;
   logic            start = 1'b0;
   logic [1:0]      op = 2'b00;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;

   rv_div_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // RISC-V M-extension semantics from plain signed/unsigned arithmetic
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx, sy;
      sx = x;
      sy = y;
      if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
      case (o)
         DIV:     return sx / sy;
         DIVU:    return x / y;
         REM:     return sx % sy;
         default: return x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
      return XLEN + 2;
   endfunction

   // Reference model: one outstanding op, identified by the cycle its done is due
   int              cyc = 0;
   bit              pend = 1'b0;
   int              done_at = 0;
   logic [XLEN-1:0] pend_res = '0;
   logic [XLEN-1:0] m_result = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= 1'b0;
         done_at  <= 0;
         m_result <= '0;
      end else begin
         if (pend && cyc == done_at) begin
            pend <= 1'b0;
         end else if (!pend && start) begin
            pend    <= 1'b1;
            done_at <= cyc + ref_lat(op, a, b);
            if (ref_lat(op, a, b) == 1) m_result <= ref_div(op, a, b);
            else                        pend_res <= ref_div(op, a, b);
         end
         if (pend && cyc + 1 == done_at) m_result <= pend_res;
      end
   end

   always @(negedge clk) begin
      chk("busy", {31'b0, busy}, {31'b0, pend && cyc < done_at});
      chk("done", {31'b0, done}, {31'b0, pend && cyc == done_at});
      chk("result", result, m_result);
   end

   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic wait_done(input string name, input int n0, input int exp_lat, input logic [31:0] exp_res);
      int n;
      n = n0;
      while (!done && n < 80) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, " latency"}, 32'(n), 32'(exp_lat));
      chk({name, " value"}, result, exp_res);
   endtask

   initial begin
      int seen;
      logic [1:0]  o;
      logic [31:0] x, y;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset busy", {31'b0, busy}, 32'h0);
      chk("reset done", {31'b0, done}, 32'h0);
      chk("reset result", result, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      start_op(DIVU, 100, 7);                 wait_done("divu 100/7", 1, 34, 32'd14);
      start_op(REMU, 100, 7);                 wait_done("remu 100/7", 1, 34, 32'd2);
      start_op(DIV, 32'hFFFF_FFF9, 2);        wait_done("div -7/2", 1, 34, 32'hFFFF_FFFD);
      start_op(REM, 32'hFFFF_FFF9, 2);        wait_done("rem -7/2", 1, 34, 32'hFFFF_FFFF);
      start_op(REM, 7, 32'hFFFF_FFFE);        wait_done("rem 7/-2", 1, 34, 32'd1);
      start_op(DIVU, 32'h1234, 0);            wait_done("divu by 0", 1, 1, 32'hFFFF_FFFF);
      start_op(REM, 32'hFFFF_FFFB, 0);        wait_done("rem by 0", 1, 1, 32'hFFFF_FFFB);
      start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div ovf", 1, 1, 32'h8000_0000);
      start_op(REM, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem ovf", 1, 1, 32'h0);
      start_op(DIV, 32'h8000_0000, 2);        wait_done("div min/2", 1, 34, 32'hC000_0000);

      // Handshake: start while busy and start during done are both ignored
      start_op(DIVU, 50, 5);
      repeat (9) begin @(posedge clk); #1; end
      op = DIVU; a = 9; b = 3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("busy start ignored", 11, 34, 32'd10);
      op = DIVU; a = 9; b = 3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start in done ignored", {31'b0, busy}, 32'h0);
      chk("result held", result, 32'd10);
      start_op(DIVU, 9, 3);
      chk("result held while busy", result, 32'd10);
      wait_done("second op", 1, 34, 32'd3);

      // Reset mid-operation aborts with no done pulse
      start_op(DIVU, 1000, 3);
      repeat (13) begin @(posedge clk); #1; end
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("abort busy", {31'b0, busy}, 32'h0);
      chk("abort done", {31'b0, done}, 32'h0);
      chk("abort result", result, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("no done after abort", 32'(seen), 32'h0);
      start_op(DIVU, 9, 3);                   wait_done("after reset", 1, 34, 32'd3);

      for (int i = 0; i < 120; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(1, 15));
            3: y = -32'($urandom_range(1, 15));
            4: x = 32'h8000_0000;
            5: y = x >> $urandom_range(0, 31);
            default: ;
         endcase
         start_op(o, x, y);
         wait_done("random", 1, ref_lat(o, x, y), ref_div(o, x, y));
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_div_unit.md
Name: rv_div_unit

Overview:
- Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Computes by repeated subtraction, one quotient bit per cycle.
- Sits beside the ALU and its carry-lookahead adder tree, behind a start/busy/done handshake.
- Core stall logic holds the pipeline while busy=1.

Parameters:
XLEN, 32, operand/result width in bits (even, >=4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
a  input  XLEN  dividend, sampled with start
b  input  XLEN  divisor, sampled with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  single-cycle pulse, result valid
result  output  XLEN  quotient or remainder per op, held until next accepted start

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal registers clear.
  - Reset asserted mid-operation aborts it; no done pulse is produced for the aborted op.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op, a, b; computes sign flags; takes magnitudes for signed ops.
  - Next state is CALC, or DONE directly for special cases.
- Special cases (fast path, DONE in the next cycle):
  - b==0: DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (DIV/REM with a = 0x8000_0000, b = 0xFFFF_FFFF): DIV result = a; REM result = 0.
- CALC:
  - Runs for exactly XLEN cycles, tracked by an iteration counter counting XLEN-1 down to 0.
  - Each cycle: shift {rem,quo} left 1, then trial = rem - divisor (XLEN+1-bit subtract).
  - If trial is non-negative: rem = trial and quo[0] = 1; otherwise rem is kept and quo[0] = 0.
  - When the counter reaches 0, go to FIX.
- FIX (1 cycle):
  - Quotient negated if signed op and sign(a) != sign(b).
  - Remainder negated if signed op and a was negative; the remainder takes the dividend's sign.
  - Selected value written to result; go to DONE.
- DONE (1 cycle):
  - done=1, busy=0; return to IDLE.
  - A start in the DONE cycle is ignored; start is accepted only in IDLE.
- busy=1 in CALC and FIX. busy=0 in IDLE and DONE.
- Latency from the start-sampling edge:
  - Normal: done high XLEN+2 cycles later (34 for XLEN=32).
  - Special case: done high 1 cycle later.
- start while busy=1 is ignored; latched operands and op do not change.
- result changes only on the edge entering DONE; it is stable in the DONE cycle and afterwards.
- Operands a and b may change freely after the sampling edge.
- Arithmetic wrap:
  - Negation is two's complement modulo 2^XLEN.
  - |0x8000_0000| treated as unsigned 0x8000_0000, which is correct for every non-overflow divisor.

Test Plan:
1. DIVU a=100, b=7 -> done exactly 34 cycles after start, result=14. Same operands with REMU -> result=2.
2. DIV a=-7 (0xFFFF_FFF9), b=2 -> result=0xFFFF_FFFD (-3). REM with same operands -> 0xFFFF_FFFF (-1). REM a=7, b=-2 -> 1.
3. Divide by zero: DIVU a=0x1234, b=0 -> done 1 cycle after start, result=0xFFFF_FFFF. REM a=-5, b=0 -> result=0xFFFF_FFFB.
4. Overflow: DIV a=0x8000_0000, b=0xFFFF_FFFF -> result=0x8000_0000 after 1 cycle. REM with same operands -> result=0.
5. Handshake:
   - DIVU 50/5 started; start pulsed with a=9, b=3 at cycle 10 -> ignored, done at cycle 34 with result=10.
   - start asserted in the DONE cycle -> ignored.
   - A new start 2 cycles later is accepted.
   - result holds 10 until that second op completes.
6. Reset mid-op: start DIVU 1000/3, assert rst at cycle 15 -> busy=0, done=0, result=0 immediately (asynchronous). No later done pulse. Release rst, run DIVU 9/3 -> result=3 at 34 cycles.
